// File: rtl/cb_pkg.sv
// Shared crossbar definitions: bus widths, slave-select field position,
// arbiter state encoding and master id type.
package cb_pkg;

  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 11;
  localparam int N_MST   = 4;
  localparam int SEL_MSB = 10;
  localparam int SEL_LSB = 9;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  typedef logic [$clog2(N_MST)-1:0] mst_id_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req    - request vector, one bit per master
//   ptr    - last served master; the search starts at ptr+1 and wraps
//   winner - id of the first requesting master found
//   valid  - at least one request present
module rr_pick
  import cb_pkg::*;
(
  input  logic [N_MST-1:0] req,
  input  mst_id_t          ptr,
  output mst_id_t          winner,
  output logic             valid
);

  mst_id_t cand;

  // Walk from the farthest offset down to ptr+1 so the nearest hit wins.
  // An offset of N_MST wraps back to ptr itself.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int k = N_MST; k >= 1; k--) begin
      cand = ptr + mst_id_t'(k);
      if (req[cand]) begin
        winner = cand;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/slave_port_arbiter.sv
// Per-slave round-robin arbiter for one slave port of the 4x4 crossbar.
// Picks one master whose address selects this slave, forwards its request
// to the slave, returns the ack and routes the following-cycle response.
// Optional build macro: SLV_ARB_TIMEOUT_EN enables the grant watchdog.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   m_req/m_addr/m_cmd/m_wdata - packed per-master request channels
//   m_ack, m_resp       - per-master one-hot ack / response strobe
//   m_rdata             - read data broadcast to all masters
//   s_req/s_addr/s_cmd/s_wdata - request forwarded to the slave
//   s_ack, s_rdata, s_resp     - slave accept and next-cycle response
//   timeout_err         - one-cycle pulse when the watchdog aborts a grant
//
// state | meaning
// IDLE  | no grant held; arbitrate among hits, register winner
// BUSY  | master gnt is forwarded to the slave until ack or withdraw
module slave_port_arbiter
  import cb_pkg::*;
#(
  parameter int SLAVE_ID    = 0,
  parameter int N_MST       = cb_pkg::N_MST,
  parameter int ADDR_W      = cb_pkg::ADDR_W,
  parameter int DATA_W      = cb_pkg::DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_MST-1:0]    m_req,
  input  logic [N_MST*ADDR_W-1:0] m_addr,
  input  logic [N_MST-1:0]    m_cmd,
  input  logic [N_MST*DATA_W-1:0] m_wdata,
  output logic [N_MST-1:0]    m_ack,
  output logic [DATA_W-1:0]   m_rdata,
  output logic [N_MST-1:0]    m_resp,
  output logic                s_req,
  output logic [ADDR_W-1:0]   s_addr,
  output logic                s_cmd,
  output logic [DATA_W-1:0]   s_wdata,
  input  logic                s_ack,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_resp,
  output logic                timeout_err
);

  localparam int SEL_W = SEL_MSB - SEL_LSB + 1;
  localparam logic [SEL_W-1:0] SEL_ID = SEL_W'(SLAVE_ID);

  arb_state_t state;
  mst_id_t    gnt, ptr, resp_own, pick_id;
  logic       resp_pend, pick_valid;
  logic       busy, ack_fire, wd_expire;

  logic [N_MST-1:0]  hit;
  logic [ADDR_W-1:0] addr_a  [N_MST];
  logic [DATA_W-1:0] wdata_a [N_MST];

  always_comb begin
    for (int i = 0; i < N_MST; i++) begin
      addr_a[i]  = m_addr[i*ADDR_W +: ADDR_W];
      wdata_a[i] = m_wdata[i*DATA_W +: DATA_W];
      hit[i]     = m_req[i] && (addr_a[i][SEL_MSB:SEL_LSB] == SEL_ID);
    end
  end

  rr_pick u_pick (
    .req    (hit),
    .ptr    (ptr),
    .winner (pick_id),
    .valid  (pick_valid)
  );

  // Reset gates every output in the cycle it is sampled, not only after.
  assign busy     = (state == BUSY) && !reset;
  assign ack_fire = busy && hit[gnt] && s_ack;

  always_comb begin
    s_req   = busy && hit[gnt];
    s_addr  = busy ? addr_a[gnt]  : '0;
    s_cmd   = busy ? m_cmd[gnt]   : 1'b0;
    s_wdata = busy ? wdata_a[gnt] : '0;
    m_ack   = '0;
    if (ack_fire) m_ack[gnt] = 1'b1;
    m_resp  = '0;
    m_rdata = '0;
    if (resp_pend && !reset) begin
      m_resp[resp_own] = s_resp;
      m_rdata          = s_rdata;
    end
  end

`ifdef SLV_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] wd_cnt;

  assign wd_expire = busy && hit[gnt] && !s_ack &&
                     (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYC[0];
  assign wd_expire = 1'b0;
`endif

  assign timeout_err = wd_expire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      ptr       <= mst_id_t'(N_MST - 1);
      resp_pend <= 1'b0;
      resp_own  <= '0;
`ifdef SLV_ARB_TIMEOUT_EN
      wd_cnt    <= '0;
`endif
    end else begin
      resp_pend <= ack_fire;
      if (ack_fire) resp_own <= gnt;
`ifdef SLV_ARB_TIMEOUT_EN
      // Held at zero in IDLE, so it starts from zero on every grant.
      if (state == IDLE) wd_cnt <= '0;
      else if (!ack_fire) wd_cnt <= wd_cnt + 1'b1;
`endif
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt   <= pick_id;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (ack_fire) begin
            ptr   <= gnt;
            state <= IDLE;
          end else if (!hit[gnt]) begin
            state <= IDLE;
          end else if (wd_expire) begin
            // Stalled master gives up its priority.
            ptr   <= gnt;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/slave_port_arbiter.md
Name: slave_port_arbiter

Overview:
- Per-slave round-robin arbiter inside the 4x4 cross bar; one instance per slave port.
- Selects one of the 4 master channels whose address targets this slave and forwards its req/addr/cmd/wdata to the slave.
- Returns ack to the granted master and routes the following-cycle rdata/resp back to the master that was acked.

Parameters:
- SLAVE_ID, 0, value of addr[SEL_MSB:SEL_LSB] that selects this slave (0..3).
- N_MST, 4, number of master channels.
- ADDR_W, 11, address width.
- DATA_W, 11, wdata/rdata width.
- TIMEOUT_CYC, 16, grant watchdog limit in cycles; used only with SLV_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- m_req  in  N_MST  per-master request.
- m_addr  in  N_MST*ADDR_W  per-master address; master i occupies bits [i*ADDR_W +: ADDR_W].
- m_cmd  in  N_MST  per-master command; 0 = read, 1 = write.
- m_wdata  in  N_MST*DATA_W  per-master write data, packed as m_addr.
- m_ack  out  N_MST  per-master ack, one-hot or zero.
- m_rdata  out  DATA_W  read data, broadcast to all masters.
- m_resp  out  N_MST  per-master response strobe, one-hot or zero.
- s_req  out  1  request to slave.
- s_addr  out  ADDR_W  address to slave.
- s_cmd  out  1  command to slave.
- s_wdata  out  DATA_W  write data to slave.
- s_ack  in  1  slave accepted request.
- s_rdata  in  DATA_W  slave read data, valid the cycle after s_ack.
- s_resp  in  1  slave response, valid the cycle after s_ack.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Qualified request: hit[i] = m_req[i] & (m_addr[i][SEL_MSB:SEL_LSB] == SLAVE_ID), with SEL_MSB = 10 and SEL_LSB = 9.
- Reset values:
  - state = IDLE; gnt = 0; ptr = N_MST-1, so master 0 wins first.
  - resp_pend = 0; resp_own = 0.
  - All outputs 0; s_* are driven 0 while IDLE.
- IDLE state:
  - If any hit, the winner is the first set bit of hit searching ptr+1, ptr+2, ... with wrap modulo N_MST.
  - Register gnt = winner and go to BUSY.
  - No combinational path from m_req to s_req; arbitration latency is 1 cycle.
- BUSY state, slave outputs:
  - s_req = hit[gnt].
  - s_addr, s_cmd, s_wdata are a combinational mux of master gnt.
- BUSY state, transitions:
  - If s_ack & hit[gnt]: m_ack[gnt] = 1 in the same cycle (combinational). Next cycle: ptr = gnt, resp_pend = 1, resp_own = gnt, state = IDLE.
  - If hit[gnt] = 0 (master withdrew or retargeted): go to IDLE with no ack; ptr is unchanged.
  - s_ack while s_req = 0 is ignored.
- Response routing:
  - When resp_pend = 1: m_resp[resp_own] = s_resp and m_rdata = s_rdata.
  - Otherwise m_resp = 0 and m_rdata = 0.
  - resp_pend clears after one cycle unless set again by a new ack.
  - Applies to both read and write commands.
- Back-to-back: a new arbitration (IDLE) can coincide with the response cycle of the previous transfer. The minimum period per transfer is 2 cycles: grant, then ack.
- Fairness: after master k is acked, the next search starts at k+1. With all 4 masters requesting continuously, acks go 0,1,2,3,0,...
- Simultaneous events: hits from several masters in IDLE resolve by round robin only. A response cycle and a new grant coexist without interaction.
- Reset mid-transfer: reset has priority over everything. It drops s_req, m_ack, m_resp and resp_pend in the cycle it is sampled; any pending response is discarded.

Optional Feature:
- Macro SLV_ARB_TIMEOUT_EN.
- Defined:
  - A counter (width $clog2(TIMEOUT_CYC)+1) clears on entering BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYC-1 without ack: state = IDLE, ptr = gnt (the stalled master loses priority), timeout_err pulses for 1 cycle, and no m_ack is issued.
- Undefined: no counter; timeout_err is tied 0; BUSY waits indefinitely.

Decomposition:
- Package cb_pkg holds:
  - ADDR_W, DATA_W, N_MST, SEL_MSB, SEL_LSB.
  - typedef enum logic {IDLE, BUSY} arb_state_t.
  - typedef logic [$clog2(N_MST)-1:0] mst_id_t.
- One sub-module, rr_pick: purely combinational round-robin picker. Inputs are req vector and ptr; outputs are winner id and valid.

Test Plan:
- Single read: m0 hits with addr=11'h005, cmd=0. Slave acks the 2nd cycle after req. Required: m_ack = 0001 in the ack cycle; next cycle m_resp = 0001 and m_rdata = s_rdata = 11'h3A5.
- All 4 masters hit continuously with immediate s_ack. Required: acks in order m0, m1, m2, m3, m0, one every 2 cycles; exactly one m_ack bit set per ack cycle.
- Address filter: SLAVE_ID = 2; m1 uses addr=11'h405 (sel 2), m3 uses addr=11'h205 (sel 1). Required: only m1 is granted; m3 never sees s_req asserted on its behalf.
- Withdraw: m2 granted, then drops m_req before s_ack. Required: next cycle IDLE, no m_ack, ptr unchanged; a pending m3 is granted next.
- Reset mid-transfer: reset in the ack cycle of a read. Required: the following cycle has m_resp = 0 and s_req = 0; after release, m0 is granted first.
- SLV_ARB_TIMEOUT_EN with TIMEOUT_CYC=16: m1 granted, s_ack held 0. Required: timeout_err pulses in BUSY cycle 16, then m2 or later wins the next arbitration.
